// File: rtl/isa_io_arbiter_if.sv
// Requester side of the ISA I/O arbiter: request/grant/completion handshake
// plus the shared request bus that only the granted requester drives.
interface isa_io_arbiter_if;
   logic [3:0]  req;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        timeout_err;
   logic [15:0] rd_data;
   logic [15:0] bus_address;
   logic [15:0] bus_data;
   logic        bus_dir;

   modport slave (
      input  req, bus_address, bus_data, bus_dir,
      output grant, done, timeout_err, rd_data
   );

   modport master (
      output req, bus_address, bus_data, bus_dir,
      input  grant, done, timeout_err, rd_data
   );
endinterface

// File: rtl/isa_io_arbiter.sv
// Round-robin owner of the riser's single ISA I/O port: grants one of four
// sequencers, latches its request bus and runs one timed IOR#/IOW# cycle.
module isa_io_arbiter #(
   parameter int SETUP_CYCLES    = 4,
   parameter int STROBE_CYCLES   = 38,
   parameter int RECOVERY_CYCLES = 8,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic                   sys_clock,
   input  logic                   reset,
   isa_io_arbiter_if.slave        rq,
   output logic [15:0]            isa_addr,
   output logic                   isa_aen,
   output logic                   isa_ior_n,
   output logic                   isa_iow_n,
   output logic [15:0]            isa_data_out,
   output logic                   isa_data_oe,
   input  logic [15:0]            isa_data_in,
   input  logic                   isa_iochrdy
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GRANT   = 3'd1,
      ST_SETUP   = 3'd2,
      ST_STROBE  = 3'd3,
      ST_RECOVER = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   // The counter starts at 0 on entry, so "last" values are length minus one.
   localparam logic [15:0] SETUP_LAST   = 16'(SETUP_CYCLES - 1);
   localparam logic [15:0] STROBE_LAST  = 16'(STROBE_CYCLES - 1);
   localparam logic [15:0] RECOVER_LAST = 16'(RECOVERY_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_r;
   state_t      next_state_s;
   logic [15:0] cnt_r;
   logic [3:0]  req_r;
   logic [1:0]  ptr_r;
   logic [1:0]  winner_s;
   logic        timeout_s;
   logic        to_flag_r;
   logic        dir_r;
   logic [3:0]  grant_r;
   logic [3:0]  done_r;
   logic        timeout_err_r;
   logic [15:0] rd_data_r;
   logic [15:0] isa_addr_r;
   logic [15:0] isa_data_out_r;
   logic        isa_aen_r;
   logic        isa_ior_n_r;
   logic        isa_iow_n_r;
   logic        isa_data_oe_r;

   // First set request after ptr wins; ptr itself is lowest priority.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      rr_pick = ptr;
      for (int i = 4; i >= 1; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) begin
            rr_pick = idx;
         end
      end
   endfunction

   assign winner_s = rr_pick(req_r, ptr_r);

   // State register
   always_ff @(posedge sys_clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode; timeout_s flags a strobe ended by the limit, not IOCHRDY
   always_comb begin
      next_state_s = state_r;
      timeout_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (|req_r) next_state_s = ST_GRANT;
            else        next_state_s = ST_IDLE;
         end
         ST_GRANT: next_state_s = ST_SETUP;
         ST_SETUP: begin
            if (cnt_r >= SETUP_LAST) next_state_s = ST_STROBE;
            else                     next_state_s = ST_SETUP;
         end
         ST_STROBE: begin
            if (cnt_r >= STROBE_LAST && isa_iochrdy) begin
               next_state_s = ST_RECOVER;
            end else if (cnt_r >= TIMEOUT_LAST) begin
               next_state_s = ST_RECOVER;
               timeout_s    = 1'b1;
            end else begin
               next_state_s = ST_STROBE;
            end
         end
         ST_RECOVER: begin
            if (cnt_r >= RECOVER_LAST) next_state_s = ST_DONE;
            else                       next_state_s = ST_RECOVER;
         end
         ST_DONE: next_state_s = ST_IDLE;
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Phase counter, RR pointer, request latch and all registered outputs
   always_ff @(posedge sys_clock) begin
      if (reset) begin
         cnt_r          <= 16'd0;
         req_r          <= 4'd0;
         ptr_r          <= 2'd3;
         to_flag_r      <= 1'b0;
         dir_r          <= 1'b0;
         grant_r        <= 4'd0;
         done_r         <= 4'd0;
         timeout_err_r  <= 1'b0;
         rd_data_r      <= 16'd0;
         isa_addr_r     <= 16'd0;
         isa_data_out_r <= 16'd0;
         isa_aen_r      <= 1'b1;
         isa_ior_n_r    <= 1'b1;
         isa_iow_n_r    <= 1'b1;
         isa_data_oe_r  <= 1'b0;
      end else begin
         req_r <= rq.req;
         cnt_r <= (next_state_s != state_r || state_r == ST_IDLE) ? 16'd0 : cnt_r + 16'd1;

         if (state_r == ST_IDLE && next_state_s == ST_GRANT) begin
            grant_r <= 4'b0001 << winner_s;
            ptr_r   <= winner_s;
         end else if (state_r == ST_DONE) begin
            grant_r <= 4'd0;
         end

         // End of GRANT: the requester's tri-state bus has settled
         if (state_r == ST_GRANT) begin
            isa_addr_r    <= rq.bus_address;
            dir_r         <= rq.bus_dir;
            isa_data_oe_r <= rq.bus_dir;
            if (rq.bus_dir) begin
               isa_data_out_r <= rq.bus_data;
            end
         end else if (state_r == ST_DONE) begin
            isa_data_oe_r <= 1'b0;
         end

         if (state_r == ST_STROBE && next_state_s == ST_RECOVER) begin
            to_flag_r <= timeout_s;
            if (!dir_r) begin
               rd_data_r <= isa_data_in;
            end
         end

         isa_aen_r     <= (next_state_s == ST_IDLE) || (next_state_s == ST_GRANT);
         isa_ior_n_r   <= !((next_state_s == ST_STROBE) && !dir_r);
         isa_iow_n_r   <= !((next_state_s == ST_STROBE) && dir_r);
         done_r        <= (next_state_s == ST_DONE) ? grant_r : 4'd0;
         timeout_err_r <= (next_state_s == ST_DONE) && to_flag_r;
      end
   end

   assign rq.grant       = grant_r;
   assign rq.done        = done_r;
   assign rq.timeout_err = timeout_err_r;
   assign rq.rd_data     = rd_data_r;
   assign isa_addr       = isa_addr_r;
   assign isa_aen        = isa_aen_r;
   assign isa_ior_n      = isa_ior_n_r;
   assign isa_iow_n      = isa_iow_n_r;
   assign isa_data_out   = isa_data_out_r;
   assign isa_data_oe    = isa_data_oe_r;

endmodule

// File: tb/tb_isa_io_arbiter.sv
// Randomized bench for isa_io_arbiter: acts as the four requesters and the ISA
// slave, and predicts each cycle from round-robin order and strobe-length arithmetic.
module tb_isa_io_arbiter;
   localparam int S  = 4;
   localparam int T  = 38;
   localparam int R  = 8;
   localparam int TO = 1000;

   logic        sys_clock = 1'b0;
   logic        reset;
   logic [15:0] isa_addr;
   logic        isa_aen;
   logic        isa_ior_n;
   logic        isa_iow_n;
   logic [15:0] isa_data_out;
   logic        isa_data_oe;
   logic [15:0] isa_data_in;
   logic        isa_iochrdy;

   isa_io_arbiter_if rq();

   isa_io_arbiter #(
      .SETUP_CYCLES(S), .STROBE_CYCLES(T), .RECOVERY_CYCLES(R), .TIMEOUT_CYCLES(TO)
   ) dut (
      .sys_clock(sys_clock), .reset(reset), .rq(rq),
      .isa_addr(isa_addr), .isa_aen(isa_aen), .isa_ior_n(isa_ior_n),
      .isa_iow_n(isa_iow_n), .isa_data_out(isa_data_out), .isa_data_oe(isa_data_oe),
      .isa_data_in(isa_data_in), .isa_iochrdy(isa_iochrdy)
   );

   always #10 sys_clock = ~sys_clock;

   logic [15:0] addr_t [4];
   logic [15:0] data_t [4];
   logic        dir_t  [4];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [3:0]  req_m;
   int          ptr_m;
   logic [15:0] rd_m;

   // Only the granted requester puts its values on the shared bus
   always_comb begin
      rq.bus_address = 16'h0000;
      rq.bus_data    = 16'h0000;
      rq.bus_dir     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (rq.grant[i]) begin
            rq.bus_address = addr_t[i];
            rq.bus_data    = data_t[i];
            rq.bus_dir     = dir_t[i];
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clock);
      #1;
   endtask

   function automatic int rr_next(input logic [3:0] m, input int p);
      for (int i = 1; i <= 4; i++) begin
         if (m[(p + i) % 4]) return (p + i) % 4;
      end
      return 0;
   endfunction

   task automatic randomize_tables();
      for (int i = 0; i < 4; i++) begin
         addr_t[i] = 16'($urandom);
         data_t[i] = 16'($urandom);
         dir_t[i]  = 1'($urandom);
      end
   endtask

   // One full arbitration + ISA cycle; IOCHRDY held low for the first n_low strobe cycles
   task automatic run_txn(input int n_low, input logic [15:0] din, input logic [3:0] add_req, input bit drop);
      int   w, wait_c, cyc, ior_lo, iow_lo, len;
      logic to_exp;
      bit   first;
      w      = rr_next(req_m, ptr_m);
      to_exp = (n_low >= TO);
      len    = to_exp ? TO : ((n_low + 1 > T) ? n_low + 1 : T);
      isa_data_in = din;
      isa_iochrdy = (n_low == 0);
      wait_c = 0;
      do begin
         tick();
         wait_c++;
         if (wait_c == 1) begin
            check_eq("idle_aen", 32'(isa_aen), 32'd1);
            check_eq("idle_oe", 32'(isa_data_oe), 32'd0);
            check_eq("idle_done", 32'(rq.done), 32'd0);
         end
      end while (rq.grant == 4'd0 && wait_c < 8);
      check_eq("grant_wait", 32'(wait_c), 32'd2);
      check_eq("grant", 32'(rq.grant), 32'(1 << w));
      if (drop) begin
         req_m[w] = 1'b0;
         rq.req   = req_m;
      end
      cyc = 0; ior_lo = 0; iow_lo = 0; first = 1'b1;
      while (rq.done == 4'd0 && cyc < TO + 200) begin
         tick();
         cyc++;
         if (!isa_ior_n) ior_lo++;
         if (!isa_iow_n) iow_lo++;
         if (first && (!isa_ior_n || !isa_iow_n)) begin
            first = 1'b0;
            check_eq("strobe_addr", 32'(isa_addr), 32'(addr_t[w]));
            check_eq("strobe_aen", 32'(isa_aen), 32'd0);
            check_eq("strobe_oe", 32'(isa_data_oe), 32'(dir_t[w]));
            check_eq("grant_onehot", 32'($countones(rq.grant)), 32'd1);
            if (dir_t[w]) check_eq("strobe_wdata", 32'(isa_data_out), 32'(data_t[w]));
         end
         isa_iochrdy = ((ior_lo + iow_lo) > n_low);
      end
      if (!dir_t[w]) rd_m = din;
      check_eq("done", 32'(rq.done), 32'(1 << w));
      check_eq("done_grant", 32'(rq.grant), 32'(1 << w));
      check_eq("timeout_err", 32'(rq.timeout_err), 32'(to_exp));
      check_eq("iow_low_cycles", 32'(iow_lo), dir_t[w] ? 32'(len) : 32'd0);
      check_eq("ior_low_cycles", 32'(ior_lo), dir_t[w] ? 32'd0 : 32'(len));
      check_eq("grant_to_done", 32'(cyc), 32'(1 + S + len + R));
      check_eq("rd_data", 32'(rq.rd_data), 32'(rd_m));
      check_eq("done_addr", 32'(isa_addr), 32'(addr_t[w]));
      ptr_m = w;
      req_m = (req_m & ~(4'b0001 << w)) | add_req;
      rq.req = req_m;
      isa_iochrdy = 1'b1;
   endtask

   initial begin
      int c;
      reset = 1'b1; rq.req = 4'd0; isa_data_in = 16'd0; isa_iochrdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addr_t[i] = 16'd0; data_t[i] = 16'd0; dir_t[i] = 1'b0;
      end
      repeat (3) tick();
      check_eq("rst_grant", 32'(rq.grant), 32'd0);
      check_eq("rst_done", 32'(rq.done), 32'd0);
      check_eq("rst_timeout", 32'(rq.timeout_err), 32'd0);
      check_eq("rst_rd_data", 32'(rq.rd_data), 32'd0);
      check_eq("rst_addr", 32'(isa_addr), 32'd0);
      check_eq("rst_aen", 32'(isa_aen), 32'd1);
      check_eq("rst_ior_n", 32'(isa_ior_n), 32'd1);
      check_eq("rst_iow_n", 32'(isa_iow_n), 32'd1);
      check_eq("rst_data_oe", 32'(isa_data_oe), 32'd0);
      check_eq("rst_data_out", 32'(isa_data_out), 32'd0);
      reset = 1'b0; ptr_m = 3; rd_m = 16'd0;

      // Single write from requester 0, then a read from requester 2
      addr_t[0] = 16'h0226; data_t[0] = 16'h0001; dir_t[0] = 1'b1;
      req_m = 4'b0001; rq.req = req_m;
      run_txn(0, 16'h5555, 4'b0100, 1'b0);
      addr_t[2] = 16'h022A; dir_t[2] = 1'b0;
      run_txn(0, 16'h00AA, 4'b0000, 1'b0);

      for (int n = 0; n < 20; n++) begin
         int sel, nl;
         randomize_tables();
         if (req_m == 4'd0) begin
            req_m = 4'($urandom_range(1, 15));
            rq.req = req_m;
         end
         sel = $urandom_range(0, 3);
         case (sel)
            1:       nl = $urandom_range(1, 60);
            2:       nl = $urandom_range(30, 120);
            default: nl = 0;
         endcase
         run_txn(nl, 16'($urandom), 4'($urandom), 1'($urandom));
      end

      // IOCHRDY extension to 100 strobe cycles, then a timeout
      randomize_tables();
      req_m = req_m | 4'b0010; rq.req = req_m;
      run_txn(99, 16'($urandom), 4'b1000, 1'b0);
      run_txn(100000, 16'($urandom), 4'b1111, 1'b0);

      // Reset asserted during STROBE
      c = 0;
      do begin tick(); c++; end while (isa_ior_n && isa_iow_n && c < 100);
      isa_iochrdy = 1'b0;
      repeat (3) tick();
      check_eq("mid_in_strobe", 32'(isa_ior_n & isa_iow_n), 32'd0);
      reset = 1'b1;
      tick();
      check_eq("mid_ior_n", 32'(isa_ior_n), 32'd1);
      check_eq("mid_iow_n", 32'(isa_iow_n), 32'd1);
      check_eq("mid_grant", 32'(rq.grant), 32'd0);
      check_eq("mid_aen", 32'(isa_aen), 32'd1);
      check_eq("mid_done", 32'(rq.done), 32'd0);
      check_eq("mid_rd_data", 32'(rq.rd_data), 32'd0);
      tick();
      check_eq("mid_done_held", 32'(rq.done), 32'd0);
      reset = 1'b0; isa_iochrdy = 1'b1;
      ptr_m = 3; rd_m = 16'd0; req_m = 4'b1111; rq.req = req_m;

      // All four held high: expect 0, 1, 2, 3, 0
      for (int n = 0; n < 5; n++) begin
         randomize_tables();
         run_txn(0, 16'($urandom), 4'b1111, 1'b0);
      end
      check_eq("rr_wrap_ptr", 32'(ptr_m), 32'd0);

      req_m = 4'd0; rq.req = req_m;
      repeat (6) tick();
      check_eq("quiet_grant", 32'(rq.grant), 32'd0);
      check_eq("quiet_aen", 32'(isa_aen), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
